// File: rtl/base_pkg.sv
// base_pkg: shared types and constants for the base skid buffer.
package base_pkg;
    typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_FULL} skid_state_t;
    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/base_skid_buf.sv
// base_skid_buf: two-entry valid/ready skid buffer with all outputs driven from flops.
// Optional saturating stall counter enabled by BASE_SKID_BUF_STALL_CNT_EN.
module base_skid_buf
    import base_pkg::*;
#(
    parameter int unsigned width = 1,
    parameter logic [width-1:0] rstv = '0,
    parameter int unsigned cnt_width = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_v,
    output logic i_r,
    input  logic [width-1:0] i_d,
    output logic o_v,
    input  logic o_r,
`ifdef BASE_SKID_BUF_STALL_CNT_EN
    output logic [width-1:0] o_d,
    output logic [cnt_width-1:0] stall_cnt
`else
    output logic [width-1:0] o_d
`endif
);
    skid_state_t state_q, state_d;
    logic [width-1:0] main_q, main_d, skid_q, skid_d;
    logic ir_q, ir_d;
    logic in_acc;
    assign in_acc = i_v & ir_q;
    always_comb begin
        state_d = state_q;
        main_d = main_q;
        skid_d = skid_q;
        case (state_q)
            SKID_EMPTY: if (in_acc) begin
                state_d = SKID_ONE;
                main_d = i_d;
            end
            SKID_ONE: begin
                if (in_acc && o_r) main_d = i_d;
                else if (in_acc) begin
                    state_d = SKID_FULL;
                    skid_d = i_d;
                end
                else if (o_r) state_d = SKID_EMPTY;
            end
            SKID_FULL: if (o_r) begin
                state_d = SKID_ONE;
                main_d = skid_q;
            end
            default: state_d = SKID_EMPTY;
        endcase
    end
    // ready looks at the next state so it never depends combinationally on o_r
    assign ir_d = state_d != SKID_FULL;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= SKID_EMPTY;
            main_q <= rstv;
            ir_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q <= main_d;
            ir_q <= ir_d;
        end
    end
    always_ff @(posedge clk) skid_q <= skid_d;
    assign o_v = state_q != SKID_EMPTY;
    assign o_d = main_q;
    assign i_r = ir_q;
`ifdef BASE_SKID_BUF_STALL_CNT_EN
    logic [cnt_width-1:0] cnt_q, cnt_d;
    assign cnt_d = (o_v && !o_r && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) cnt_q <= !reset ? '0 : cnt_d;
    assign stall_cnt = cnt_q;
`endif
endmodule
